// File: rtl/memory_lsu_if.sv
// memory_lsu_if: request/response bundle between the execute/memory pipeline
// register, the memory LSU and the writeback stage.
//   req_*   : load/store request with valid/ready handshake (master drives)
//   resp_*  : registered load response or misalignment error (slave drives)
//   sb_count_m : store-buffer occupancy (slave drives)
interface memory_lsu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int SB_DEPTH   = 4
);
  logic                        req_valid_m;
  logic                        req_ready_m;
  logic                        req_write_m;
  logic [1:0]                  req_size_m;
  logic                        req_unsigned_m;
  logic [DATA_WIDTH-1:0]       alu_result_lo_m;
  logic [DATA_WIDTH-1:0]       data_mem_write_data_m;
  logic [4:0]                  reg_file_write_addr_m;
  logic                        resp_valid_m;
  logic [DATA_WIDTH-1:0]       resp_data_m;
  logic [4:0]                  resp_reg_addr_m;
  logic                        misalign_m;
  logic [$clog2(SB_DEPTH):0]   sb_count_m;

  modport master (
    output req_valid_m, req_write_m, req_size_m, req_unsigned_m,
           alu_result_lo_m, data_mem_write_data_m, reg_file_write_addr_m,
    input  req_ready_m, resp_valid_m, resp_data_m, resp_reg_addr_m,
           misalign_m, sb_count_m
  );

  modport slave (
    input  req_valid_m, req_write_m, req_size_m, req_unsigned_m,
           alu_result_lo_m, data_mem_write_data_m, reg_file_write_addr_m,
    output req_ready_m, resp_valid_m, resp_data_m, resp_reg_addr_m,
           misalign_m, sb_count_m
  );
endinterface

// File: rtl/memory_lsu.sv
// memory_lsu: memory stage with byte/half/word loads and stores, a posted
// store buffer, misalignment flagging and an internal single-port data RAM.
//   clock_m : clock, rising edge
//   reset_m : asynchronous active-high reset
//   bus     : memory_lsu_if slave (request handshake, response, sb_count_m)
module memory_lsu #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int SB_DEPTH    = 4
) (
  input  logic          clock_m,
  input  logic          reset_m,
  memory_lsu_if.slave   bus
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] addr;
  logic [AW-1:0] req_idx;
  logic [1:0]    off;
  logic          misalign;
  logic          unused_addr_bits;

  assign addr             = bus.alu_result_lo_m;
  assign req_idx          = addr[AW+1:2];
  assign off              = addr[1:0];
  assign unused_addr_bits = ^addr[DW-1:AW+2];
  assign misalign = ((bus.req_size_m == 2'b01) && off[0]) ||
                    (bus.req_size_m[1] && (off != 2'b00));

  // Store buffer: circular FIFO of {word index, byte mask, replicated data}
  logic [AW-1:0] sb_idx  [SB_DEPTH];
  logic [3:0]    sb_mask [SB_DEPTH];
  logic [DW-1:0] sb_data [SB_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic [PW-1:0] rel [SB_DEPTH];
  logic [SB_DEPTH-1:0] slot_live;
  logic          conflict;

  assign full = (count == CW'(SB_DEPTH));

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      rel[i]       = PW'(i) - rd_ptr;
      slot_live[i] = ({1'b0, rel[i]} < count);
      if (slot_live[i] && (sb_idx[i] == req_idx)) conflict = 1'b1;
    end
  end

  logic ready;
  always_comb begin
    ready = 1'b0;
    if (misalign)             ready = 1'b1;
    else if (full)            ready = 1'b0;
    else if (bus.req_write_m) ready = 1'b1;
    else                      ready = !conflict;
  end
  assign bus.req_ready_m = ready;

  logic accept, load_acc, store_acc, err_acc, drain;
  assign accept    = bus.req_valid_m && ready;
  assign load_acc  = accept && !bus.req_write_m && !misalign;
  assign store_acc = accept &&  bus.req_write_m && !misalign;
  assign err_acc   = accept && misalign;
  // The RAM port is free for a drain whenever no load claims it.
  assign drain     = !load_acc && (count != '0);

  logic [3:0]    push_mask;
  logic [DW-1:0] push_data;
  always_comb begin
    push_mask = 4'b1111;
    push_data = bus.data_mem_write_data_m;
    case (bus.req_size_m)
      2'b00: begin
        push_mask = 4'b0001 << off;
        push_data = {4{bus.data_mem_write_data_m[7:0]}};
      end
      2'b01: begin
        push_mask = 4'b0011 << {off[1], 1'b0};
        push_data = {2{bus.data_mem_write_data_m[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_m or posedge reset_m) begin
    if (reset_m) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store_acc) wr_ptr <= wr_ptr + PW'(1);
      if (drain)     rd_ptr <= rd_ptr + PW'(1);
      case ({store_acc, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_m) begin
    if (store_acc) begin
      sb_idx[wr_ptr]  <= req_idx;
      sb_mask[wr_ptr] <= push_mask;
      sb_data[wr_ptr] <= push_data;
    end
  end

  // Data RAM: contents and load metadata are deliberately not reset.
  logic [DW-1:0] mem [DEPTH_WORDS];
  logic [DW-1:0] ram_q;
  logic [1:0]    ld_off;
  logic [1:0]    ld_size;
  logic          ld_uns;

  always_ff @(posedge clock_m) begin
    if (drain) begin
      for (int b = 0; b < 4; b++) begin
        if (sb_mask[rd_ptr][b]) mem[sb_idx[rd_ptr]][8*b +: 8] <= sb_data[rd_ptr][8*b +: 8];
      end
    end
    if (load_acc) begin
      ram_q   <= mem[req_idx];
      ld_off  <= off;
      ld_size <= bus.req_size_m;
      ld_uns  <= bus.req_unsigned_m;
    end
  end

  logic       resp_valid, resp_mis, resp_is_load;
  logic [4:0] resp_reg;

  always_ff @(posedge clock_m or posedge reset_m) begin
    if (reset_m) begin
      resp_valid   <= 1'b0;
      resp_mis     <= 1'b0;
      resp_is_load <= 1'b0;
      resp_reg     <= '0;
    end else begin
      resp_valid <= load_acc || err_acc;
      resp_mis   <= err_acc;
      if (load_acc || err_acc) begin
        resp_is_load <= load_acc;
        resp_reg     <= bus.reg_file_write_addr_m;
      end
    end
  end

  // Lane select and extension act on the registered RAM word.
  logic [DW-1:0] shifted, ext;
  always_comb begin
    shifted = ram_q >> {ld_off, 3'b000};
    case (ld_size)
      2'b00:   ext = ld_uns ? {{(DW-8){1'b0}}, shifted[7:0]}
                            : {{(DW-8){shifted[7]}}, shifted[7:0]};
      2'b01:   ext = ld_uns ? {{(DW-16){1'b0}}, shifted[15:0]}
                            : {{(DW-16){shifted[15]}}, shifted[15:0]};
      default: ext = ram_q;
    endcase
  end

  assign bus.resp_valid_m    = resp_valid;
  assign bus.misalign_m      = resp_mis;
  assign bus.resp_reg_addr_m = resp_reg;
  assign bus.resp_data_m     = resp_is_load ? ext : '0;
  assign bus.sb_count_m      = count;
endmodule

// File: tb/tb_memory_lsu.sv
// tb_memory_lsu: directed stimulus for memory_lsu with a word-array memory
// model plus pending-store queue, checked every cycle, and literal checks.
module tb_memory_lsu;
  localparam int SBD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_lsu_if #(.DATA_WIDTH(32), .SB_DEPTH(SBD)) bus();

  memory_lsu #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .SB_DEPTH(SBD)) dut (
    .clock_m(clk),
    .reset_m(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: architectural memory plus queue of posted stores
  typedef struct {
    logic [9:0]  idx;
    logic [1:0]  size;
    logic [1:0]  off;
    logic [31:0] data;
  } st_t;

  logic [31:0] mmem [1024];
  st_t         pend [$];
  logic        exp_rv   = 1'b0;
  logic        exp_mis  = 1'b0;
  logic [31:0] exp_data = '0;
  logic [4:0]  exp_reg  = '0;

  function automatic logic is_mis(input logic [1:0] sz, input logic [1:0] o);
    if (sz == 2'b01) return o[0];
    if (sz[1])       return o != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic model_ready();
    if (is_mis(bus.req_size_m, bus.alu_result_lo_m[1:0])) return 1'b1;
    if (pend.size() == SBD) return 1'b0;
    if (bus.req_write_m) return 1'b1;
    foreach (pend[k]) if (pend[k].idx == bus.alu_result_lo_m[11:2]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] lane_load(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] o, input logic u);
    logic [31:0] v;
    v = w >> (8 * int'(o));
    if (sz == 2'b00) begin
      v = v & 32'h0000_00FF;
      if (!u && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = v & 32'h0000_FFFF;
      if (!u && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic apply_store(input st_t s);
    if (s.size == 2'b00)      mmem[s.idx][8*int'(s.off) +: 8]     = s.data[7:0];
    else if (s.size == 2'b01) mmem[s.idx][16*int'(s.off[1]) +: 16] = s.data[15:0];
    else                      mmem[s.idx] = s.data;
  endtask

  always @(posedge clk or posedge rst) begin : model
    logic acc, mis, ld;
    st_t  s;
    if (rst) begin
      pend.delete();
      exp_rv  = 1'b0;
      exp_mis = 1'b0;
    end else begin
      mis = is_mis(bus.req_size_m, bus.alu_result_lo_m[1:0]);
      acc = bus.req_valid_m && model_ready();
      ld  = acc && !bus.req_write_m && !mis;
      exp_rv  = acc && (mis || !bus.req_write_m);
      exp_mis = acc && mis;
      if (exp_rv) begin
        exp_reg  = bus.reg_file_write_addr_m;
        exp_data = mis ? 32'h0 : lane_load(mmem[bus.alu_result_lo_m[11:2]], bus.req_size_m,
                                           bus.alu_result_lo_m[1:0], bus.req_unsigned_m);
      end
      if (!ld && pend.size() > 0) begin
        apply_store(pend[0]);
        void'(pend.pop_front());
      end
      if (acc && bus.req_write_m && !mis) begin
        s.idx  = bus.alu_result_lo_m[11:2];
        s.size = bus.req_size_m;
        s.off  = bus.alu_result_lo_m[1:0];
        s.data = bus.data_mem_write_data_m;
        pend.push_back(s);
      end
    end
  end

  always @(negedge clk) begin
    chk("resp_valid", 32'(bus.resp_valid_m), 32'(exp_rv));
    chk("misalign", 32'(bus.misalign_m), 32'(exp_mis));
    if (exp_rv) begin
      chk("resp_data", bus.resp_data_m, exp_data);
      chk("resp_reg", 32'(bus.resp_reg_addr_m), 32'(exp_reg));
    end
    chk("sb_count", 32'(bus.sb_count_m), 32'(pend.size()));
    if (bus.req_valid_m && !rst) chk("req_ready", 32'(bus.req_ready_m), 32'(model_ready()));
  end

  task automatic set_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    bus.req_valid_m           = 1'b1;
    bus.req_write_m           = w;
    bus.req_size_m            = sz;
    bus.req_unsigned_m        = u;
    bus.alu_result_lo_m       = a;
    bus.data_mem_write_data_m = d;
    bus.reg_file_write_addr_m = r;
  endtask

  // Returns one time unit after the accepting edge, valid still asserted.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    logic rdy;
    set_req(w, sz, u, a, d, r);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      rdy = bus.req_ready_m;
      @(posedge clk);
      #1;
      if (rdy) return;
    end
    checks++;
    errors++;
    $display("FAIL handshake_timeout: addr %h not accepted within 20 cycles", a);
  endtask

  task automatic idle(input int n);
    bus.req_valid_m = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_lit(input string name, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [4:0] r, input logic [31:0] exp);
    do_req(1'b0, sz, u, a, 32'h0, r);
    bus.req_valid_m = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, 32'(bus.resp_valid_m), 32'h1);
    chk({name, "_data"}, bus.resp_data_m, exp);
    chk({name, "_reg"}, 32'(bus.resp_reg_addr_m), 32'(r));
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req_valid_m           = 1'b0;
    bus.req_write_m           = 1'b0;
    bus.req_size_m            = 2'b10;
    bus.req_unsigned_m        = 1'b0;
    bus.alu_result_lo_m       = '0;
    bus.data_mem_write_data_m = '0;
    bus.reg_file_write_addr_m = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(bus.req_ready_m), 32'h1);
    chk("reset_count", 32'(bus.sb_count_m), 32'h0);
    chk("reset_resp_valid", 32'(bus.resp_valid_m), 32'h0);
    chk("reset_resp_data", bus.resp_data_m, 32'h0);
    @(posedge clk);
    #1;

    // Load-after-store to the same word stalls until drained
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0);
    set_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd5);
    @(negedge clk);
    chk("stall_ready", 32'(bus.req_ready_m), 32'h0);
    chk("stall_count", 32'(bus.sb_count_m), 32'h1);
    load_lit("raw_word", 2'b10, 1'b0, 32'h10, 5'd5, 32'hDEADBEEF);

    // Byte store into a known word, then extended loads
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 5'd0);
    do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h00000080, 5'd0);
    load_lit("ldb_signed", 2'b00, 1'b0, 32'h21, 5'd7, 32'hFFFFFF80);
    load_lit("ldb_unsigned", 2'b00, 1'b1, 32'h21, 5'd8, 32'h00000080);
    load_lit("ldh_hi", 2'b01, 1'b0, 32'h22, 5'd9, 32'h00001122);
    load_lit("ldh_lo_signed", 2'b01, 1'b0, 32'h20, 5'd10, 32'hFFFF8044);
    load_lit("ldw_merged", 2'b10, 1'b0, 32'h20, 5'd11, 32'h11228044);

    // Misaligned requests: error pulse, no RAM or buffer effect
    do_req(1'b1, 2'b10, 1'b0, 32'h00, 32'h01020304, 5'd0);
    do_req(1'b1, 2'b10, 1'b0, 32'h04, 32'hCAFEF00D, 5'd0);
    idle(2);
    do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 5'd12);
    bus.req_valid_m = 1'b0;
    @(negedge clk);
    chk("mis_load_flag", 32'(bus.misalign_m), 32'h1);
    chk("mis_load_data", bus.resp_data_m, 32'h0);
    chk("mis_load_reg", 32'(bus.resp_reg_addr_m), 32'd12);
    @(posedge clk);
    #1;
    do_req(1'b1, 2'b01, 1'b0, 32'h03, 32'h0000BEEF, 5'd13);
    bus.req_valid_m = 1'b0;
    @(negedge clk);
    chk("mis_store_flag", 32'(bus.misalign_m), 32'h1);
    chk("mis_store_count", 32'(bus.sb_count_m), 32'h0);
    @(posedge clk);
    #1;
    load_lit("after_mis_w0", 2'b10, 1'b0, 32'h00, 5'd1, 32'h01020304);
    load_lit("after_mis_w1", 2'b10, 1'b0, 32'h04, 5'd2, 32'hCAFEF00D);

    // Back-to-back stores to distinct words, then read back in order
    for (int i = 0; i < SBD + 2; i++)
      do_req(1'b1, 2'b10, 1'b0, 32'h100 + 32'(4 * i), 32'hA0000000 + 32'(i), 5'd0);
    idle(1);
    for (int i = 0; i < SBD + 2; i++)
      load_lit("burst_read", 2'b10, 1'b0, 32'h100 + 32'(4 * i), 5'(i + 16), 32'hA0000000 + 32'(i));

    // Reset discards a pending store; RAM keeps the prior value
    do_req(1'b1, 2'b10, 1'b0, 32'h200, 32'h55555555, 5'd0);
    idle(2);
    do_req(1'b1, 2'b10, 1'b0, 32'h200, 32'h66666666, 5'd0);
    bus.req_valid_m = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_count", 32'(bus.sb_count_m), 32'h0);
    chk("rst_resp_valid", 32'(bus.resp_valid_m), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    load_lit("rst_old_data", 2'b10, 1'b0, 32'h200, 5'd3, 32'h55555555);

    // Address wrap past the RAM depth
    do_req(1'b1, 2'b10, 1'b0, 32'h1000, 32'h0BADF00D, 5'd0);
    load_lit("wrap", 2'b10, 1'b0, 32'h0000, 5'd4, 32'h0BADF00D);

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
